peak_window_ctrl: RTL and testbench
===================================

# peak_window_ctrl

Sequencer for windowed peak search on the filtered signal stream. It arms on a threshold crossing, then tracks the signed maximum and its sample index over a fixed window of valid samples. It emits one registered peak report and then blanks the input for a refractory period before re-arming. It sits after the filter chain and feeds peak value and position to downstream interval/rate logic.

## Interface

- DATA_WIDTH, 11, signed sample width
- WIN_LEN, 64, search window length in accepted samples (≥1), including the trigger sample
- REFRACT_LEN, 40, blanking length in accepted samples (≥0)
- CNT_WIDTH, 16, width of sample index counter
- i_clk  in  1  clock, all state on rising edge
- i_nrst  in  1  asynchronous active-low reset
- i_ce  in  1  clock enable; gates sample acceptance
- i_signal  in  DATA_WIDTH  signed sample
- i_signal_valid  in  1  sample qualifier
- i_threshold  in  DATA_WIDTH  signed arming threshold
- o_peak  out  DATA_WIDTH  signed peak value of last window
- o_peak_idx  out  CNT_WIDTH  sample index of that peak
- o_peak_valid  out  1  one-cycle report strobe
- o_busy  out  1  high whenever state ≠ IDLE

## Operation

- Accepted sample: `i_ce && i_signal_valid` on a rising edge. Every counter and window update happens on accepted samples only.
- Sample counter `sample_cnt` (CNT_WIDTH):
  - The first accepted sample after reset has index 0.
  - Increments on every accepted sample in every state.
  - Wraps from 2^CNT_WIDTH−1 to 0.
- States: IDLE, SEARCH, REPORT, REFRACT.
- IDLE:
  - An accepted sample with `i_signal > i_threshold` (strict, signed) loads `max=i_signal`, `max_idx=sample_cnt`, `win_cnt=1`.
  - Next state is SEARCH, or REPORT if WIN_LEN==1.
  - `i_threshold` is sampled only here; changes during other states have no effect.
- SEARCH, on each accepted sample:
  - If `i_signal > max` (strict, signed), load `max` and `max_idx`. Ties keep the earlier index.
  - `win_cnt++`.
  - When the sample just accepted is the WIN_LEN-th of the window, go to REPORT.
- REPORT, lasts exactly one clock regardless of i_ce:
  - o_peak_valid=1, with o_peak/o_peak_idx presenting max/max_idx.
  - A sample accepted in this cycle is not evaluated. It does count toward refractory.
  - Next state is REFRACT with `ref_cnt` = 1 if a sample was accepted, else 0.
  - If REFRACT_LEN==0, go to IDLE and drop that sample.
- REFRACT:
  - Accepted samples increment `ref_cnt` and are otherwise ignored.
  - When `ref_cnt` reaches REFRACT_LEN, go to IDLE.
  - The first sample evaluated for re-arming is the one after the REFRACT_LEN-th.
  - If REPORT already reached REFRACT_LEN (REFRACT_LEN==1 with a sample in REPORT), go directly to IDLE.
- o_peak and o_peak_idx are registered. They hold their value until the next REPORT.
- Width rules:
  - All comparisons are signed DATA_WIDTH.
  - `win_cnt` and `ref_cnt` are sized with $clog2(max(len,1)+1).
  - No saturation is needed.

## Timing

- Reset (asynchronous, immediate):
  - State=IDLE.
  - sample_cnt, win_cnt, ref_cnt, max, max_idx = 0.
  - o_peak=0, o_peak_idx=0, o_peak_valid=0, o_busy=0.
- Reset mid-window or mid-refractory aborts without a report. o_peak_valid never asserts for an aborted window.
- Latency: o_peak_valid is high in the clock cycle immediately following the edge that accepts the WIN_LEN-th window sample. It is high for exactly 1 cycle.
- o_busy rises in the cycle after the trigger edge. It falls in the cycle after the edge that completes refractory (or after REPORT if REFRACT_LEN==0).
- Gaps (i_signal_valid=0 or i_ce=0) stall SEARCH/REFRACT indefinitely with no timeout. State and counters hold.
- Back-to-back valid samples every cycle are fully supported. No input is ever backpressured.

## Test plan

Use WIN_LEN=4, REFRACT_LEN=3, CNT_WIDTH=16 unless noted.

- Reset: assert i_nrst=0 mid-clock → all outputs 0 without waiting for an edge. Release and feed 10 samples below threshold → o_busy stays 0, no strobe.
- Basic window: threshold=100, stream 50,120,300,200,250,10 every cycle → trigger at idx1. Exactly one strobe, 1 cycle after the idx4 edge, with o_peak=300, o_peak_idx=2. o_peak holds 300 afterwards.
- Ties and signed compare:
  - threshold=100, stream 150,150,80,90 → o_peak=150, idx of first 150.
  - threshold=−50, stream −40,−10,−30,−20 → o_peak=−10.
  - −60 at threshold=−50 does not trigger.
- Refractory: after the basic window, stream 500,500,500,500 → first three ignored (o_busy=1). The fourth triggers a new window.
- Stalls: insert i_signal_valid=0 and i_ce=0 cycles inside SEARCH → o_peak_idx counts only accepted samples, and the report timing shifts by the stall count.
- Abort and wrap:
  - Async reset during SEARCH → no strobe, o_busy=0 immediately, next trigger indexes from 0.
  - With CNT_WIDTH=4, 20 samples → indices wrap 15→0 and a peak at the 17th sample reports idx 0.

Source files
------------

// File: rtl/peak_window_ctrl_if.sv
// Sample stream, arming threshold and peak report bundle for peak_window_ctrl.
// The slave side is the peak detector; the master side is the upstream filter / sink.
interface peak_window_ctrl_if #(
   parameter int unsigned DATA_WIDTH = 11,
   parameter int unsigned CNT_WIDTH  = 16
);
   logic                         i_ce;
   logic signed [DATA_WIDTH-1:0] i_signal;
   logic                         i_signal_valid;
   logic signed [DATA_WIDTH-1:0] i_threshold;
   logic signed [DATA_WIDTH-1:0] o_peak;
   logic        [CNT_WIDTH-1:0]  o_peak_idx;
   logic                         o_peak_valid;
   logic                         o_busy;

   modport master (
      output i_ce, i_signal, i_signal_valid, i_threshold,
      input  o_peak, o_peak_idx, o_peak_valid, o_busy
   );

   modport slave (
      input  i_ce, i_signal, i_signal_valid, i_threshold,
      output o_peak, o_peak_idx, o_peak_valid, o_busy
   );
endinterface

// File: rtl/peak_window_ctrl.sv
// Threshold-armed windowed peak search: tracks the signed maximum and its sample index
// over WIN_LEN accepted samples, reports once, then blanks for REFRACT_LEN samples.
module peak_window_ctrl #(
   parameter int unsigned DATA_WIDTH  = 11,
   parameter int unsigned WIN_LEN     = 64,
   parameter int unsigned REFRACT_LEN = 40,
   parameter int unsigned CNT_WIDTH   = 16
) (
   input  logic              i_clk,
   input  logic              i_nrst,
   peak_window_ctrl_if.slave bus
);

   typedef enum logic [1:0] {IDLE, SEARCH, REPORT, REFRACT} state_t;

   localparam int unsigned WIN_W   = $clog2(WIN_LEN + 1);
   localparam int unsigned REF_MAX = (REFRACT_LEN < 1) ? 1 : REFRACT_LEN;
   localparam int unsigned REF_W   = $clog2(REF_MAX + 1);
   localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN_LEN - 1);
   localparam logic [REF_W-1:0] REF_LAST = REF_W'(REF_MAX - 1);

   state_t                       state_q, state_d;
   logic [CNT_WIDTH-1:0]         sample_q, sample_d;
   logic [WIN_W-1:0]             win_q, win_d;
   logic [REF_W-1:0]             ref_q, ref_d;
   logic signed [DATA_WIDTH-1:0] max_q, max_d;
   logic [CNT_WIDTH-1:0]         idx_q, idx_d;
   logic signed [DATA_WIDTH-1:0] peak_q, peak_d;
   logic [CNT_WIDTH-1:0]         peak_idx_q, peak_idx_d;
   logic                         accept;

   assign accept = bus.i_ce && bus.i_signal_valid;

   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
         state_q    <= IDLE;
         sample_q   <= '0;
         win_q      <= '0;
         ref_q      <= '0;
         max_q      <= '0;
         idx_q      <= '0;
         peak_q     <= '0;
         peak_idx_q <= '0;
      end else begin
         state_q    <= state_d;
         sample_q   <= sample_d;
         win_q      <= win_d;
         ref_q      <= ref_d;
         max_q      <= max_d;
         idx_q      <= idx_d;
         peak_q     <= peak_d;
         peak_idx_q <= peak_idx_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      sample_d   = sample_q;
      win_d      = win_q;
      ref_d      = ref_q;
      max_d      = max_q;
      idx_d      = idx_q;
      peak_d     = peak_q;
      peak_idx_d = peak_idx_q;

      if (accept) sample_d = sample_q + CNT_WIDTH'(1);

      unique case (state_q)
         IDLE: begin
            if (accept && (bus.i_signal > bus.i_threshold)) begin
               max_d   = bus.i_signal;
               idx_d   = sample_q;
               win_d   = WIN_W'(1);
               state_d = (WIN_LEN == 1) ? REPORT : SEARCH;
            end
         end
         SEARCH: begin
            if (accept) begin
               // Strict compare so ties keep the earlier index.
               if (bus.i_signal > max_q) begin
                  max_d = bus.i_signal;
                  idx_d = sample_q;
               end
               win_d = win_q + WIN_W'(1);
               if (win_q == WIN_LAST) state_d = REPORT;
            end
         end
         REPORT: begin
            // The sample accepted here is never evaluated but counts as refractory.
            ref_d = accept ? REF_W'(1) : '0;
            if (REFRACT_LEN == 0) begin
               ref_d   = '0;
               state_d = IDLE;
            end else if ((REFRACT_LEN == 1) && accept) begin
               state_d = IDLE;
            end else begin
               state_d = REFRACT;
            end
         end
         REFRACT: begin
            if (accept) begin
               ref_d = ref_q + REF_W'(1);
               if (ref_q == REF_LAST) state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // Load the report registers on entry so they are valid alongside the strobe.
      if ((state_d == REPORT) && (state_q != REPORT)) begin
         peak_d     = max_d;
         peak_idx_d = idx_d;
      end
   end

   assign bus.o_peak       = peak_q;
   assign bus.o_peak_idx   = peak_idx_q;
   assign bus.o_peak_valid = (state_q == REPORT);
   assign bus.o_busy       = (state_q != IDLE);

endmodule

// File: tb/tb_peak_window_ctrl.sv
// Directed bench for peak_window_ctrl: WIN_LEN=4, REFRACT_LEN=3, with a second
// CNT_WIDTH=4 instance for sample index wrap.
module tb_peak_window_ctrl;

   logic clk  = 1'b0;
   logic nrst = 1'b0;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   peak_window_ctrl_if #(.DATA_WIDTH(11), .CNT_WIDTH(16)) bus_a ();
   peak_window_ctrl_if #(.DATA_WIDTH(11), .CNT_WIDTH(4))  bus_b ();

   peak_window_ctrl #(
      .DATA_WIDTH(11), .WIN_LEN(4), .REFRACT_LEN(3), .CNT_WIDTH(16)
   ) dut_a (
      .i_clk (clk),
      .i_nrst(nrst),
      .bus   (bus_a.slave)
   );

   peak_window_ctrl #(
      .DATA_WIDTH(11), .WIN_LEN(4), .REFRACT_LEN(3), .CNT_WIDTH(4)
   ) dut_b (
      .i_clk (clk),
      .i_nrst(nrst),
      .bus   (bus_b.slave)
   );

   // Drive one cycle on the selected instance; outputs are observed 1 time unit after the edge.
   task automatic step(input int sel, input int sig, input logic vld, input logic ce);
      bus_a.i_signal_valid = 1'b0;
      bus_b.i_signal_valid = 1'b0;
      if (sel == 0) begin
         bus_a.i_signal       = 11'(sig);
         bus_a.i_signal_valid = vld;
         bus_a.i_ce           = ce;
      end else begin
         bus_b.i_signal       = 11'(sig);
         bus_b.i_signal_valid = vld;
         bus_b.i_ce           = ce;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      #2 nrst = 1'b0;
      #4 nrst = 1'b1;
   endtask

   task automatic test_reset();
      int s;
      #1;
      checks++;
      if (bus_a.o_peak_valid !== 1'b0 || bus_a.o_busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_ctrl: valid=%b busy=%b want 0 0", bus_a.o_peak_valid, bus_a.o_busy);
      end
      checks++;
      if (bus_a.o_peak !== 11'sd0 || bus_a.o_peak_idx !== 16'd0) begin
         errors++;
         $display("FAIL reset_data: peak=%0d idx=%0d want 0 0", bus_a.o_peak, bus_a.o_peak_idx);
      end
      #11 nrst = 1'b1;
      bus_a.i_threshold = 11'sd100;
      for (int i = 1; i <= 10; i++) begin
         s = i * 10;
         step(0, s, 1'b1, 1'b1);
         checks++;
         if (bus_a.o_busy !== 1'b0 || bus_a.o_peak_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_below_thr[%0d]: busy=%b valid=%b want 0 0", i, bus_a.o_busy, bus_a.o_peak_valid);
         end
      end
   endtask

   task automatic test_basic();
      int   sv [5] = '{50, 120, 300, 200, 250};
      logic ev [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      logic eb [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      apply_reset();
      bus_a.i_threshold = 11'sd100;
      for (int i = 0; i < 5; i++) begin
         step(0, sv[i], 1'b1, 1'b1);
         checks++;
         if (bus_a.o_peak_valid !== ev[i] || bus_a.o_busy !== eb[i]) begin
            errors++;
            $display("FAIL basic_seq[%0d]: valid=%b busy=%b want %b %b", i, bus_a.o_peak_valid, bus_a.o_busy, ev[i], eb[i]);
         end
      end
      checks++;
      if (bus_a.o_peak !== 11'sd300 || bus_a.o_peak_idx !== 16'd2) begin
         errors++;
         $display("FAIL basic_report: peak=%0d idx=%0d want 300 2", bus_a.o_peak, bus_a.o_peak_idx);
      end
      step(0, 0, 1'b0, 1'b1);
      checks++;
      if (bus_a.o_peak_valid !== 1'b0 || bus_a.o_peak !== 11'sd300 || bus_a.o_busy !== 1'b1) begin
         errors++;
         $display("FAIL basic_hold: valid=%b peak=%0d busy=%b want 0 300 1", bus_a.o_peak_valid, bus_a.o_peak, bus_a.o_busy);
      end
   endtask

   // Continues from test_basic: refractory entered with no sample during REPORT.
   task automatic test_refract();
      logic eb [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
      bus_a.i_threshold = 11'sd1000;   // ignored outside IDLE; restored before re-arm
      for (int i = 0; i < 4; i++) begin
         if (i == 3) bus_a.i_threshold = 11'sd100;
         step(0, 500, 1'b1, 1'b1);
         checks++;
         if (bus_a.o_busy !== eb[i] || bus_a.o_peak_valid !== 1'b0) begin
            errors++;
            $display("FAIL refract[%0d]: busy=%b valid=%b want %b 0", i, bus_a.o_busy, bus_a.o_peak_valid, eb[i]);
         end
      end
      for (int i = 0; i < 3; i++) step(0, 400, 1'b1, 1'b1);
      checks++;
      if (bus_a.o_peak_valid !== 1'b1 || bus_a.o_peak !== 11'sd500 || bus_a.o_peak_idx !== 16'd8) begin
         errors++;
         $display("FAIL refract_rearm: valid=%b peak=%0d idx=%0d want 1 500 8", bus_a.o_peak_valid, bus_a.o_peak, bus_a.o_peak_idx);
      end
   endtask

   task automatic test_ties_signed();
      int tv [4] = '{150, 150, 80, 90};
      int nv [5] = '{-60, -40, -10, -30, -20};
      apply_reset();
      bus_a.i_threshold = 11'sd100;
      for (int i = 0; i < 4; i++) step(0, tv[i], 1'b1, 1'b1);
      checks++;
      if (bus_a.o_peak_valid !== 1'b1 || bus_a.o_peak !== 11'sd150 || bus_a.o_peak_idx !== 16'd0) begin
         errors++;
         $display("FAIL ties: valid=%b peak=%0d idx=%0d want 1 150 0", bus_a.o_peak_valid, bus_a.o_peak, bus_a.o_peak_idx);
      end
      apply_reset();
      bus_a.i_threshold = -11'sd50;
      step(0, nv[0], 1'b1, 1'b1);
      checks++;
      if (bus_a.o_busy !== 1'b0) begin
         errors++;
         $display("FAIL signed_no_trig: busy=%b want 0", bus_a.o_busy);
      end
      for (int i = 1; i < 5; i++) step(0, nv[i], 1'b1, 1'b1);
      checks++;
      if (bus_a.o_peak_valid !== 1'b1 || bus_a.o_peak !== -11'sd10 || bus_a.o_peak_idx !== 16'd2) begin
         errors++;
         $display("FAIL signed_peak: valid=%b peak=%0d idx=%0d want 1 -10 2", bus_a.o_peak_valid, bus_a.o_peak, bus_a.o_peak_idx);
      end
   endtask

   task automatic test_stalls();
      int   sv [7] = '{120, 999, 999, 130, 200, 999, 150};
      logic vv [7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
      logic cv [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      logic ev [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      apply_reset();
      bus_a.i_threshold = 11'sd100;
      for (int i = 0; i < 7; i++) begin
         step(0, sv[i], vv[i], cv[i]);
         checks++;
         if (bus_a.o_peak_valid !== ev[i] || bus_a.o_busy !== 1'b1) begin
            errors++;
            $display("FAIL stall_seq[%0d]: valid=%b busy=%b want %b 1", i, bus_a.o_peak_valid, bus_a.o_busy, ev[i]);
         end
      end
      checks++;
      if (bus_a.o_peak !== 11'sd200 || bus_a.o_peak_idx !== 16'd2) begin
         errors++;
         $display("FAIL stall_report: peak=%0d idx=%0d want 200 2", bus_a.o_peak, bus_a.o_peak_idx);
      end
   endtask

   task automatic test_back_to_back();
      int   sv [4] = '{200, 1, 1, 1};
      logic eb [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
      apply_reset();
      bus_a.i_threshold = 11'sd100;
      for (int i = 0; i < 4; i++) step(0, sv[i], 1'b1, 1'b1);
      checks++;
      if (bus_a.o_peak_valid !== 1'b1 || bus_a.o_peak !== 11'sd200 || bus_a.o_peak_idx !== 16'd0) begin
         errors++;
         $display("FAIL b2b_report: valid=%b peak=%0d idx=%0d want 1 200 0", bus_a.o_peak_valid, bus_a.o_peak, bus_a.o_peak_idx);
      end
      for (int i = 0; i < 4; i++) begin
         step(0, 300, 1'b1, 1'b1);
         checks++;
         if (bus_a.o_busy !== eb[i] || bus_a.o_peak_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_refract[%0d]: busy=%b valid=%b want %b 0", i, bus_a.o_busy, bus_a.o_peak_valid, eb[i]);
         end
      end
   endtask

   task automatic test_abort();
      apply_reset();
      bus_a.i_threshold = 11'sd100;
      step(0, 200, 1'b1, 1'b1);
      step(0, 210, 1'b1, 1'b1);
      #3 nrst = 1'b0;
      #1;
      checks++;
      if (bus_a.o_busy !== 1'b0 || bus_a.o_peak_valid !== 1'b0) begin
         errors++;
         $display("FAIL abort_immediate: busy=%b valid=%b want 0 0", bus_a.o_busy, bus_a.o_peak_valid);
      end
      #3 nrst = 1'b1;
      step(0, 0, 1'b0, 1'b1);
      checks++;
      if (bus_a.o_peak_valid !== 1'b0 || bus_a.o_peak !== 11'sd0) begin
         errors++;
         $display("FAIL abort_no_strobe: valid=%b peak=%0d want 0 0", bus_a.o_peak_valid, bus_a.o_peak);
      end
      step(0, 300, 1'b1, 1'b1);
      for (int i = 0; i < 3; i++) step(0, 0, 1'b1, 1'b1);
      checks++;
      if (bus_a.o_peak_valid !== 1'b1 || bus_a.o_peak !== 11'sd300 || bus_a.o_peak_idx !== 16'd0) begin
         errors++;
         $display("FAIL abort_reindex: valid=%b peak=%0d idx=%0d want 1 300 0", bus_a.o_peak_valid, bus_a.o_peak, bus_a.o_peak_idx);
      end
   endtask

   task automatic test_wrap();
      apply_reset();
      bus_b.i_threshold = 11'sd100;
      for (int i = 0; i < 16; i++) step(1, 5, 1'b1, 1'b1);
      step(1, 250, 1'b1, 1'b1);
      checks++;
      if (bus_b.o_busy !== 1'b1) begin
         errors++;
         $display("FAIL wrap_trigger: busy=%b want 1", bus_b.o_busy);
      end
      step(1, 10, 1'b1, 1'b1);
      step(1, 20, 1'b1, 1'b1);
      step(1, 30, 1'b1, 1'b1);
      checks++;
      if (bus_b.o_peak_valid !== 1'b1 || bus_b.o_peak !== 11'sd250 || bus_b.o_peak_idx !== 4'd0) begin
         errors++;
         $display("FAIL wrap_report: valid=%b peak=%0d idx=%0d want 1 250 0", bus_b.o_peak_valid, bus_b.o_peak, bus_b.o_peak_idx);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus_a.i_ce = 1'b1; bus_a.i_signal = '0; bus_a.i_signal_valid = 1'b0; bus_a.i_threshold = '0;
      bus_b.i_ce = 1'b1; bus_b.i_signal = '0; bus_b.i_signal_valid = 1'b0; bus_b.i_threshold = '0;
      test_reset();
      test_basic();
      test_refract();
      test_ties_signed();
      test_stalls();
      test_back_to_back();
      test_abort();
      test_wrap();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
